// File: rtl/zx_autotype_sched.sv
// -----------------------------------------------------------------------------
// zx_autotype_sched
// Autotype scheduler for the ZX Spectrum 8x5 key matrix. Key codes from a
// loader/OSD are queued in a small FIFO. Each code is then pressed for
// HOLD_TICKS video frames and released for GAP_TICKS frames. The injected keys
// are merged with the live PS/2 matrix, and the result serves the CPU port-0xFE
// row read selected by addr_hi.
//
// Build option: define AUTOTYPE_LIVE_MASK_EN to ignore live keys while a key is
// being played back. This covers both the PRESS and GAP states. When the macro
// is left undefined, live and injected keys are always wired-ANDed.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   frame_tick     one-cycle pulse per video frame
//   in_code[7:0]   [7]=CAPS SHIFT, [6]=SYM SHIFT, [5:0]=key index (40..63 = pause)
//   in_valid       in_code valid
//   in_ready       FIFO has room
//   inject_en      playback enable
//   abort          flush the queue and release all keys (synchronous)
//   live_matrix_n  live keys, active low, bit index = row*5+col
//   addr_hi[7:0]   CPU A15..A8; a low bit r selects row r
//   key_data_n[4:0] merged row data, active low (combinational)
//   busy           a key is in progress or the FIFO is non-empty
// -----------------------------------------------------------------------------
module zx_autotype_sched #(
  parameter int HOLD_TICKS = 3,
  parameter int GAP_TICKS  = 2,
  parameter int FIFO_AW    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [7:0]  in_code,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        inject_en,
  input  logic        abort,
  input  logic [39:0] live_matrix_n,
  input  logic [7:0]  addr_hi,
  output logic [4:0]  key_data_n,
  output logic        busy
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} state_t;

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;

  state_t      state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        push, pop;
  logic [39:0] overlay;
  logic [39:0] live_eff;
  logic [4:0]  row_sel [8];
  logic [4:0]  key_acc;

  // The count only reaches its top bit when exactly DEPTH entries are held.
  assign in_ready = ~count_q[FIFO_AW];
  assign push     = in_valid && in_ready && !abort;
  assign pop      = (state_q == ST_IDLE) && inject_en && (count_q != '0) && !abort;
  assign busy     = (state_q != ST_IDLE) || (count_q != '0);

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
      if (pop)  rd_ptr_q <= rd_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
      case ({push, pop})
        2'b10:   count_q <= count_q + {{FIFO_AW{1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{FIFO_AW{1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // The frame counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A tick arriving in the pop cycle is not counted.
          if (pop) begin
            state_d = ST_PRESS;
            code_d  = fifo_mem[rd_ptr_q];
            cnt_d   = '0;
          end
        end
        ST_PRESS: begin
          if (frame_tick) begin
            if (int'(cnt_inc) >= HOLD_TICKS) begin
              state_d = ST_GAP;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_GAP: begin
          if (frame_tick) begin
            if (int'(cnt_inc) >= GAP_TICKS) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- overlay
  // Pause indices (40..63) press no key, but the modifier bits still apply.
  always_comb begin
    overlay = '0;
    if (state_q == ST_PRESS) begin
      if (code_q[5:0] < 6'd40) overlay[code_q[5:0]] = 1'b1;
      if (code_q[7])           overlay[0]           = 1'b1;
      if (code_q[6])           overlay[36]          = 1'b1;
    end
  end

`ifdef AUTOTYPE_LIVE_MASK_EN
  assign live_eff = (state_q != ST_IDLE) ? '1 : live_matrix_n;
`else
  assign live_eff = live_matrix_n;
`endif

  // Rows that are not addressed contribute all-ones to the AND.
  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    assign row_sel[gi] = addr_hi[gi] ? 5'h1F
                                     : (live_eff[gi*5 +: 5] & ~overlay[gi*5 +: 5]);
  end

  always_comb begin
    key_acc = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      key_acc = key_acc & row_sel[r];
    end
  end

  assign key_data_n = key_acc;

endmodule

// File: tb/tb_zx_autotype_sched.sv
module tb_zx_autotype_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [7:0]  in_code = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        inject_en = 1'b0;
  logic        abort = 1'b0;
  logic [39:0] live_matrix_n = '1;
  logic [7:0]  addr_hi = 8'hFF;
  logic [4:0]  key_data_n;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard of expected pressed-key maps (active high, bit = row*5+col).
  logic [39:0] sb_q [$];

  always #10 clk = ~clk;

  zx_autotype_sched #(
    .HOLD_TICKS (3),
    .GAP_TICKS  (2),
    .FIFO_AW    (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .in_code       (in_code),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .inject_en     (inject_en),
    .abort         (abort),
    .live_matrix_n (live_matrix_n),
    .addr_hi       (addr_hi),
    .key_data_n    (key_data_n),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got %h expected %h ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive frame_tick for one edge; outputs are sampled 1 ns after the edge.
  task automatic cycle(input logic t);
    frame_tick = t;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  function automatic logic [39:0] key_map(input logic [7:0] c);
    logic [39:0] m;
    m = '0;
    if (c[5:0] < 6'd40) m[c[5:0]] = 1'b1;
    if (c[7]) m[0]  = 1'b1;
    if (c[6]) m[36] = 1'b1;
    return m;
  endfunction

  task automatic scan(output logic [39:0] m);
    m = '0;
    for (int r = 0; r < 8; r++) begin
      addr_hi = 8'hFF ^ (8'(1) << r);
      #1;
      m[r*5 +: 5] = ~key_data_n;
    end
    addr_hi = 8'hFF;
  endtask

  task automatic read_row(input logic [7:0] a, output logic [4:0] d);
    addr_hi = a;
    #1;
    d = key_data_n;
    addr_hi = 8'hFF;
  endtask

  task automatic push(input logic [7:0] c, input logic exp_ready, input bit sb_add);
    check($sformatf("in_ready push %h", c), 64'(in_ready), 64'(exp_ready));
    in_code  = c;
    in_valid = 1'b1;
    cycle(1'b0);
    in_valid = 1'b0;
    if (exp_ready && sb_add) sb_q.push_back(key_map(c));
  endtask

  task automatic expect_press(input string tag);
    logic [39:0] m;
    scan(m);
    if (sb_q.size() == 0) check({tag, " sb empty"}, 64'(m), 64'(0));
    else                  check(tag, 64'(m), 64'(sb_q.pop_front()));
  endtask

  // Free-running playback monitor: every new press is compared against the
  // scoreboard head; ends when the scoreboard is drained and the DUT is idle.
  task automatic run_play(input int period, input int budget, input string tag);
    logic [39:0] m, prev;
    bit done;
    prev = '0;
    done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      cycle((k % period) == period - 1);
      scan(m);
      if (m != '0 && prev == '0) begin
        if (sb_q.size() == 0) check({tag, " extra key"}, 64'(m), 64'(0));
        else                  check(tag, 64'(m), 64'(sb_q.pop_front()));
      end
      prev = m;
      if (!busy && sb_q.size() == 0) done = 1;
    end
    check({tag, " completed"}, 64'(done), 64'(1));
  endtask

  initial begin
    logic [4:0]  d;
    logic [39:0] m;
    logic [7:0]  codes [9];

    // ---------------- reset
    cycle(1'b0);
    cycle(1'b0);
    check("reset busy", 64'(busy), 64'(0));
    check("reset in_ready", 64'(in_ready), 64'(1));
    read_row(8'h00, d);
    check("reset all rows", 64'(d), 64'(5'h1F));
    rst_n = 1'b1;
    cycle(1'b0);

    // ---------------- 1: single key A, precise hold/gap timing
    inject_en = 1'b1;
    push(8'h05, 1'b1, 1'b1);
    check("t1 busy after push", 64'(busy), 64'(1));
    read_row(8'hFD, d);
    check("t1 FD before pop", 64'(d), 64'(5'h1F));
    cycle(1'b1);                      // pop cycle; this tick is ignored
    expect_press("t1 press map");
    read_row(8'hFD, d);
    check("t1 FD pressed", 64'(d), 64'(5'h1E));
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    read_row(8'hFD, d);
    check("t1 FD after 2 ticks", 64'(d), 64'(5'h1E));
    cycle(1'b1);
    read_row(8'hFD, d);
    check("t1 FD after 3rd tick", 64'(d), 64'(5'h1F));
    check("t1 busy in gap", 64'(busy), 64'(1));
    cycle(1'b1);
    check("t1 busy gap tick1", 64'(busy), 64'(1));
    cycle(1'b1);
    check("t1 busy gap tick2", 64'(busy), 64'(0));

    // ---------------- 2: CAPS SHIFT + 1
    push(8'h8F, 1'b1, 1'b1);
    cycle(1'b0);
    expect_press("t2 press map");
    read_row(8'hFE, d);
    check("t2 FE", 64'(d), 64'(5'h1E));
    read_row(8'hF7, d);
    check("t2 F7", 64'(d), 64'(5'h1E));
    read_row(8'hF6, d);
    check("t2 F6", 64'(d), 64'(5'h1E));
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    read_row(8'h00, d);
    check("t2 released", 64'(d), 64'(5'h1F));
    cycle(1'b1);
    cycle(1'b1);
    check("t2 busy done", 64'(busy), 64'(0));

    // ---------------- 3: fill FIFO, overflow, ordered playback
    codes[0] = 8'h01; codes[1] = 8'h22; codes[2] = 8'h43; codes[3] = 8'h10;
    codes[4] = 8'h27; codes[5] = 8'h88; codes[6] = 8'h19; codes[7] = 8'h0C;
    codes[8] = 8'h1D;
    inject_en = 1'b0;
    for (int i = 0; i < 9; i++) push(codes[i], (i < 8), 1'b1);
    check("t3 in_ready full", 64'(in_ready), 64'(0));
    check("t3 busy queued", 64'(busy), 64'(1));
    inject_en = 1'b1;
    run_play(3, 600, "t3 play");
    check("t3 in_ready drained", 64'(in_ready), 64'(1));

    // ---------------- 4: abort mid-PRESS with queued keys
    inject_en = 1'b0;
    push(8'h14, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 1'b1, 1'b0);
    inject_en = 1'b1;
    cycle(1'b0);
    expect_press("t4 press map");
    cycle(1'b1);
    abort    = 1'b1;
    in_code  = 8'h05;
    in_valid = 1'b1;                  // dropped by abort
    cycle(1'b0);
    abort    = 1'b0;
    in_valid = 1'b0;
    check("t4 busy", 64'(busy), 64'(0));
    check("t4 in_ready", 64'(in_ready), 64'(1));
    scan(m);
    check("t4 all rows released", 64'(m), 64'(0));
    cycle(1'b0);
    cycle(1'b0);
    check("t4 queue flushed", 64'(busy), 64'(0));

    // ---------------- 5: live Q held, inject W
    live_matrix_n[10] = 1'b0;
    read_row(8'hFB, d);
    check("t5 FB live only", 64'(d), 64'(5'h1E));
    push(8'h0B, 1'b1, 1'b0);
    cycle(1'b0);
    read_row(8'hFB, d);
`ifdef AUTOTYPE_LIVE_MASK_EN
    check("t5 FB merged", 64'(d), 64'(5'h1D));
`else
    check("t5 FB merged", 64'(d), 64'(5'h1C));
`endif
    for (int i = 0; i < 5; i++) cycle(1'b1);
    check("t5 busy done", 64'(busy), 64'(0));
    read_row(8'hFB, d);
    check("t5 FB live after", 64'(d), 64'(5'h1E));
    live_matrix_n = '1;

    // ---------------- 6: pause code
    push(8'h3F, 1'b1, 1'b0);
    cycle(1'b0);
    scan(m);
    check("t6 no key at pop", 64'(m), 64'(0));
    check("t6 busy at pop", 64'(busy), 64'(1));
    for (int t = 1; t <= 5; t++) begin
      cycle(1'b1);
      scan(m);
      check($sformatf("t6 no key tick%0d", t), 64'(m), 64'(0));
      check($sformatf("t6 busy tick%0d", t), 64'(busy), 64'(t < 5));
    end

    check("scoreboard empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
